// File: rtl/f_backtrack.sv
// Traceback of the F/B segmentation table: follows back-pointers B(k,i) from
// (K, i_last) down to k=1 and emits one (k, start, end) segment per formant.
module f_backtrack #(
  parameter int I        = 160,
  parameter int FORMANTS = 5,
  parameter int JW       = $clog2(I) + 1
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          start,
  input  logic [$clog2(I)-1:0]          i_last,
  input  logic [$clog2(FORMANTS):0]     k_total,
  output logic [$clog2(FORMANTS)-1:0]   b_k_req,
  output logic [$clog2(I)-1:0]          b_i_req,
  output logic                          b_req_valid,
  input  logic signed [JW-1:0]          b_rd_data,
  output logic [$clog2(FORMANTS)-1:0]   seg_k,
  output logic [$clog2(I)-1:0]          seg_start,
  output logic [$clog2(I)-1:0]          seg_end,
  output logic                          seg_valid,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);

  localparam int IW = $clog2(I);
  localparam int KW = $clog2(FORMANTS);
  localparam logic signed [JW-1:0] NEG1 = '1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    CHECK,
    EMIT,
    FINISH
  } state_t;

  state_t          state;
  logic [KW-1:0]   cur_k;
  logic [IW-1:0]   cur_i;

  logic            args_bad;
  logic [IW:0]     i_last_p1;
  logic signed [JW-1:0] j;
  logic signed [JW-1:0] cur_i_s;
  logic signed [JW-1:0] km2_s;
  logic            j_bad;

  // K segments need at least K frames, and K must fit the table.
  assign i_last_p1 = {1'b0, i_last} + (IW+1)'(1);
  assign args_bad  = (k_total == '0)
                  || (k_total > (KW+1)'(FORMANTS))
                  || ((IW+1)'(k_total) > i_last_p1);

  assign j       = b_rd_data;
  assign cur_i_s = JW'({1'b0, cur_i});
  assign km2_s   = JW'(cur_k) - JW'(2);

  // A pointer must leave at least one frame for each remaining lower segment.
  assign j_bad = (j < NEG1)
              || (j >= cur_i_s)
              || ((cur_k == KW'(1)) && (j != NEG1))
              || ((cur_k > KW'(1)) && (j < km2_s));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= IDLE;
      cur_k       <= '0;
      cur_i       <= '0;
      b_k_req     <= '0;
      b_i_req     <= '0;
      b_req_valid <= 1'b0;
      seg_k       <= '0;
      seg_start   <= '0;
      seg_end     <= '0;
      seg_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cur_i <= i_last;
            cur_k <= k_total[KW-1:0];
            if (args_bad) begin
              done  <= 1'b1;
              error <= 1'b1;
              state <= FINISH;
            end else begin
              busy        <= 1'b1;
              b_req_valid <= 1'b1;
              b_k_req     <= k_total[KW-1:0];
              b_i_req     <= i_last;
              state       <= REQ;
            end
          end
        end

        REQ: begin
          b_req_valid <= 1'b0;
          state       <= WAIT;
        end

        WAIT: begin
          state <= CHECK;
        end

        CHECK: begin
          if (j_bad) begin
            done  <= 1'b1;
            error <= 1'b1;
            state <= FINISH;
          end else begin
            seg_valid <= 1'b1;
            seg_k     <= cur_k;
            seg_start <= IW'(j + JW'(1));
            seg_end   <= cur_i;
            state     <= EMIT;
            if (cur_k == KW'(1)) begin
              done  <= 1'b1;
              error <= 1'b0;
            end else begin
              // Next read overlaps this segment's emission cycle.
              b_req_valid <= 1'b1;
              b_k_req     <= cur_k - KW'(1);
              b_i_req     <= IW'(j);
              cur_k       <= cur_k - KW'(1);
              cur_i       <= IW'(j);
            end
          end
        end

        EMIT: begin
          seg_valid   <= 1'b0;
          b_req_valid <= 1'b0;
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= WAIT;
          end
        end

        FINISH: begin
          done  <= 1'b0;
          error <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_f_backtrack.sv
// Randomized bench for f_backtrack: a B-table memory with 2-cycle read latency
// and a per-cycle timeline model derived from the traceback rules.
module tb_f_backtrack;
  localparam int I  = 160;
  localparam int F  = 5;
  localparam int IW = 8;
  localparam int KW = 3;
  localparam int JW = 9;
  localparam int NC = 32;

  logic                  clk_in = 1'b0;
  logic                  rst_n_in = 1'b0;
  logic                  start = 1'b0;
  logic [IW-1:0]         i_last = '0;
  logic [KW:0]           k_total = '0;
  logic [KW-1:0]         b_k_req;
  logic [IW-1:0]         b_i_req;
  logic                  b_req_valid;
  logic signed [JW-1:0]  b_rd_data = '0;
  logic [KW-1:0]         seg_k;
  logic [IW-1:0]         seg_start;
  logic [IW-1:0]         seg_end;
  logic                  seg_valid;
  logic                  busy;
  logic                  done;
  logic                  error;

  f_backtrack #(.I(I), .FORMANTS(F), .JW(JW)) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .start       (start),
    .i_last      (i_last),
    .k_total     (k_total),
    .b_k_req     (b_k_req),
    .b_i_req     (b_i_req),
    .b_req_valid (b_req_valid),
    .b_rd_data   (b_rd_data),
    .seg_k       (seg_k),
    .seg_start   (seg_start),
    .seg_end     (seg_end),
    .seg_valid   (seg_valid),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;
  int tcyc  = 0;
  bit mon_en = 1'b0;

  int btab [0:7][0:I-1];

  // B-table memory: data for a request appears 2 cycles later, garbage otherwise.
  logic                 p1_valid = 1'b0;
  logic signed [JW-1:0] p1_data = '0;

  function automatic logic signed [JW-1:0] mem_rd(input logic [KW-1:0] k, input logic [IW-1:0] i);
    if (int'(i) >= I) return '0;
    return JW'(btab[k][i]);
  endfunction

  always @(posedge clk_in) begin
    p1_valid  <= b_req_valid;
    p1_data   <= mem_rd(b_k_req, b_i_req);
    b_rd_data <= p1_valid ? p1_data : JW'($urandom);
  end

  // Expected per-cycle timeline, cycle 0 = start cycle.
  int exp_req [0:NC-1];
  int exp_rk  [0:NC-1];
  int exp_ri  [0:NC-1];
  int exp_seg [0:NC-1];
  int exp_sk  [0:NC-1];
  int exp_ss  [0:NC-1];
  int exp_se  [0:NC-1];
  int exp_busy[0:NC-1];
  int exp_done[0:NC-1];
  int exp_err [0:NC-1];

  typedef struct {
    int cyc;
    int k;
    int a;
    int b;
  } ev_t;
  ev_t rd_log[$];
  ev_t seg_log[$];
  ev_t done_log[$];

  task automatic chk(input string nm, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, tcyc, act, exp_v);
    end
  endtask

  always @(negedge clk_in) begin
    if (mon_en && tcyc < NC) begin
      chk("req_valid", int'(b_req_valid), exp_req[tcyc]);
      if (exp_req[tcyc] != 0) begin
        chk("req_k", int'(b_k_req), exp_rk[tcyc]);
        chk("req_i", int'(b_i_req), exp_ri[tcyc]);
      end
      chk("seg_valid", int'(seg_valid), exp_seg[tcyc]);
      if (exp_seg[tcyc] != 0) begin
        chk("seg_k", int'(seg_k), exp_sk[tcyc]);
        chk("seg_start", int'(seg_start), exp_ss[tcyc]);
        chk("seg_end", int'(seg_end), exp_se[tcyc]);
      end
      chk("busy", int'(busy), exp_busy[tcyc]);
      chk("done", int'(done), exp_done[tcyc]);
      if (exp_done[tcyc] != 0) chk("error", int'(error), exp_err[tcyc]);
      if (b_req_valid) rd_log.push_back('{tcyc, int'(b_k_req), int'(b_i_req), 0});
      if (seg_valid) seg_log.push_back('{tcyc, int'(seg_k), int'(seg_start), int'(seg_end)});
      if (done) done_log.push_back('{tcyc, int'(error), 0, 0});
    end
    if (mon_en) tcyc++;
  end

  // Walk the pointer chain by the traceback rules and lay events on a timeline.
  task automatic build_model(input int kt, input int il, output int last);
    int k, i, j, c, cc;
    bit bad;
    for (int n = 0; n < NC; n++) begin
      exp_req[n] = 0; exp_rk[n] = 0; exp_ri[n] = 0;
      exp_seg[n] = 0; exp_sk[n] = 0; exp_ss[n] = 0; exp_se[n] = 0;
      exp_busy[n] = 0; exp_done[n] = 0; exp_err[n] = 0;
    end
    if (kt == 0 || kt > F || kt > il + 1) begin
      exp_done[1] = 1;
      exp_err[1]  = 1;
      last = 1;
      return;
    end
    k = kt; i = il; c = 1;
    exp_req[c] = 1; exp_rk[c] = k; exp_ri[c] = i;
    forever begin
      j  = btab[k][i];
      cc = c + 3;
      bad = (j < -1) || (j >= i) || (k == 1 && j != -1) || (k > 1 && j < k - 2);
      if (bad) begin
        exp_done[cc] = 1; exp_err[cc] = 1;
        break;
      end
      exp_seg[cc] = 1; exp_sk[cc] = k; exp_ss[cc] = j + 1; exp_se[cc] = i;
      if (k == 1) begin
        exp_done[cc] = 1; exp_err[cc] = 0;
        break;
      end
      exp_req[cc] = 1; exp_rk[cc] = k - 1; exp_ri[cc] = j;
      k = k - 1; i = j; c = cc;
    end
    last = cc;
    for (int n = 1; n <= last; n++) exp_busy[n] = 1;
  endtask

  task automatic fill_garbage();
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < I; i++)
        btab[k][i] = int'($urandom_range(0, 511)) - 256;
  endtask

  task automatic run(input int kt, input int il, input int extra_c, input int abort_c);
    int last;
    build_model(kt, il, last);
    rd_log.delete(); seg_log.delete(); done_log.delete();
    for (int c = 0; c <= last + 2; c++) begin
      if (c == 0) begin
        start = 1'b1; k_total = 4'(kt); i_last = 8'(il);
        tcyc = 0; mon_en = 1'b1;
      end else if (c == extra_c) begin
        start = 1'b1;
        k_total = 4'($urandom_range(1, 5));
        i_last = 8'($urandom_range(0, 159));
      end else begin
        start = 1'b0;
      end
      if (c == abort_c) begin
        #2;
        mon_en = 1'b0; start = 1'b0; rst_n_in = 1'b0;
        #1;
        chk("rst_req_valid", int'(b_req_valid), 0);
        chk("rst_req_k", int'(b_k_req), 0);
        chk("rst_req_i", int'(b_i_req), 0);
        chk("rst_seg_valid", int'(seg_valid), 0);
        chk("rst_seg_k", int'(seg_k), 0);
        chk("rst_seg_start", int'(seg_start), 0);
        chk("rst_seg_end", int'(seg_end), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        repeat (3) begin
          @(negedge clk_in);
          chk("rst_hold_done", int'(done), 0);
          chk("rst_hold_seg", int'(seg_valid), 0);
        end
        @(posedge clk_in); #2 rst_n_in = 1'b1;
        @(negedge clk_in);
        chk("post_rst_done", int'(done), 0);
        chk("post_rst_busy", int'(busy), 0);
        @(posedge clk_in); #1;
        break;
      end
      @(posedge clk_in); #1;
    end
    start = 1'b0;
    mon_en = 1'b0;
  endtask

  task automatic setup_s1();
    fill_garbage();
    btab[3][99] = 59;
    btab[2][59] = 19;
    btab[1][19] = -1;
  endtask

  // Hand-derived timeline of the three-segment example.
  task automatic check_s1_literals();
    int rc[3] = '{1, 4, 7};
    int rk[3] = '{3, 2, 1};
    int ri[3] = '{99, 59, 19};
    int sc[3] = '{4, 7, 10};
    int ss[3] = '{60, 20, 0};
    int se[3] = '{99, 59, 19};
    chk("s1_nreads", rd_log.size(), 3);
    chk("s1_nsegs", seg_log.size(), 3);
    chk("s1_ndone", done_log.size(), 1);
    for (int n = 0; n < 3; n++) begin
      if (n < rd_log.size()) begin
        chk("s1_rd_cyc", rd_log[n].cyc, rc[n]);
        chk("s1_rd_k", rd_log[n].k, rk[n]);
        chk("s1_rd_i", rd_log[n].a, ri[n]);
      end
      if (n < seg_log.size()) begin
        chk("s1_seg_cyc", seg_log[n].cyc, sc[n]);
        chk("s1_seg_k", seg_log[n].k, rk[n]);
        chk("s1_seg_start", seg_log[n].a, ss[n]);
        chk("s1_seg_end", seg_log[n].b, se[n]);
      end
    end
    if (done_log.size() > 0) begin
      chk("s1_done_cyc", done_log[0].cyc, 10);
      chk("s1_done_err", done_log[0].k, 0);
    end
  endtask

  task automatic gen_random(output int kt, output int il, output bit busy_run);
    int k, i, j, idx, n, choice;
    int pk[8];
    int pi[8];
    fill_garbage();
    busy_run = 1'b1;
    if ($urandom_range(0, 99) < 15) begin
      busy_run = 1'b0;
      choice = $urandom_range(0, 2);
      if (choice == 0) begin kt = 0; il = $urandom_range(0, 159); end
      else if (choice == 1) begin kt = $urandom_range(6, 15); il = $urandom_range(0, 159); end
      else begin il = $urandom_range(0, 3); kt = il + 2; end
      return;
    end
    kt = $urandom_range(1, 5);
    il = $urandom_range(kt - 1, 159);
    k = kt; i = il; n = 0;
    while (k > 1) begin
      j = $urandom_range(k - 2, i - 1);
      btab[k][i] = j;
      pk[n] = k; pi[n] = i; n++;
      i = j; k--;
    end
    btab[1][i] = -1;
    pk[n] = 1; pi[n] = i; n++;
    if ($urandom_range(0, 99) < 30) begin
      idx = $urandom_range(0, n - 1);
      k = pk[idx]; i = pi[idx];
      choice = $urandom_range(0, 3);
      case (choice)
        0: j = i;
        1: j = i + $urandom_range(1, 5);
        2: j = -2 - int'($urandom_range(0, 3));
        default: j = (k > 1) ? k - 3 : int'($urandom_range(0, 255));
      endcase
      btab[k][i] = j;
    end
  endtask

  initial begin
    int kt, il, extra;
    bit busy_run;

    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_req_valid", int'(b_req_valid), 0);
    chk("reset_seg_valid", int'(seg_valid), 0);
    @(posedge clk_in); #1 rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    setup_s1();
    run(3, 99, -1, -1);
    check_s1_literals();

    fill_garbage();
    btab[1][0] = -1;
    run(1, 0, -1, -1);
    chk("single_nsegs", seg_log.size(), 1);
    if (done_log.size() > 0) chk("single_done_cyc", done_log[0].cyc, 4);

    fill_garbage();
    btab[2][10] = 10;
    run(2, 10, -1, -1);
    chk("badptr_nsegs", seg_log.size(), 0);
    if (done_log.size() > 0) begin
      chk("badptr_done_cyc", done_log[0].cyc, 4);
      chk("badptr_err", done_log[0].k, 1);
    end

    fill_garbage();
    btab[2][10] = 4;
    btab[1][4] = 2;
    run(2, 10, -1, -1);
    chk("badk1_nsegs", seg_log.size(), 1);
    if (done_log.size() > 0) chk("badk1_done_cyc", done_log[0].cyc, 7);

    run(0, 50, -1, -1);
    chk("k0_nreads", rd_log.size(), 0);
    run(6, 50, -1, -1);
    chk("k6_nreads", rd_log.size(), 0);
    run(5, 2, -1, -1);
    chk("kbig_nreads", rd_log.size(), 0);

    setup_s1();
    run(3, 99, 2, -1);
    check_s1_literals();

    setup_s1();
    run(3, 99, -1, 5);
    run(3, 99, -1, -1);
    check_s1_literals();

    for (int t = 0; t < 60; t++) begin
      gen_random(kt, il, busy_run);
      extra = -1;
      if (busy_run && $urandom_range(0, 99) < 30) extra = $urandom_range(1, 4);
      run(kt, il, extra, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
